// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: operation encoding, flag bit
// positions and the response record queued in the response FIFO.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int ALU_W = 32;

  typedef logic [3:0] alu_flags_t;

  // Canonical response record at the default operand width.
  typedef struct packed {
    logic [ALU_W-1:0] result;
    alu_flags_t       flags;
  } alu_rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with occupancy count and wrapping pointers.
// Storage is not reset; the head reads as zero whenever the FIFO is empty.
module alu_rsp_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution wrapper: computes result/NZCV on accept and queues
// responses in order. Define ALU_STICKY_V_EN to enable the sticky overflow bit.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  input  logic             clr_sticky,
  output logic             sticky_v
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
  } rsp_t;

  // Add and subtract share one adder; subtract feeds ~B with carry-in 1, so
  // C=1 means no borrow and V compares against the inverted operand's sign.
  function automatic rsp_t alu_compute(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input alu_op_t          op);
    rsp_t             r;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    bb       = (op == ALU_SUB) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (op == ALU_SUB)};
    r.result = '0;
    r.flags  = '0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        r.result        = sum[WIDTH-1:0];
        r.flags[FLAG_C] = sum[WIDTH];
        r.flags[FLAG_V] = (a[WIDTH-1] == bb[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: r.result = a & b;
      default: r.result = a | b;
    endcase
    r.flags[FLAG_N] = r.result[WIDTH-1];
    r.flags[FLAG_Z] = (r.result == '0);
    return r;
  endfunction

  rsp_t rsp_p0;
  rsp_t head;
  logic full;
  logic empty;
  logic accept;
  logic pop;

  assign rsp_p0    = alu_compute(req_a, req_b, alu_op_t'(req_ctrl));
  assign req_ready = !full;
  assign rsp_valid = !empty;
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Stage boundary: computed response registered into the FIFO tail.
  alu_rsp_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (pop),
    .wr_data (rsp_p0),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign rsp_result = head.result;
  assign rsp_flags  = head.flags;

`ifdef ALU_STICKY_V_EN
  logic arith_p0;
  assign arith_p0 = (req_ctrl == ALU_ADD) || (req_ctrl == ALU_SUB);

  always_ff @(posedge clk) begin
    if (!reset_n)
      sticky_v <= 1'b0;
    else if (accept && arith_p0 && rsp_p0.flags[FLAG_V])
      sticky_v <= 1'b1;
    else if (clr_sticky)
      sticky_v <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign sticky_v   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; sticky expectations follow ALU_STICKY_V_EN.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
`ifdef ALU_STICKY_V_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_ctrl;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             clr_sticky;
  logic             sticky_v;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .clr_sticky (clr_sticky),
    .sticky_v   (sticky_v)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge (caller ensures req_ready=1).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    req_a = a; req_b = b; req_ctrl = op; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (sticky_v !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", sticky_v); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", rsp_result); end
    checks++; if (rsp_flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", rsp_flags); end
  endtask

  task automatic test_ops();
    logic [31:0] va [8] = '{32'h1FFF_FFFF, 32'hFF0F_FFFF, 32'hF0F0_F0F0, 32'h5,
                            32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] vb [8] = '{32'h1FFF_FFFF, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h5,
                            32'h1, 32'h1, 32'h1, 32'h1};
    logic [1:0]  vo [8] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    logic [31:0] vr [8] = '{32'h3FFF_FFFE, 32'hFF0F_FFFF, 32'hFFFF_FFFF, 32'h0,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF};
    logic [3:0]  vf [8] = '{4'b0000, 4'b1000, 4'b1000, 4'b0110,
                            4'b1000, 4'b1001, 4'b0110, 4'b0011};
    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i], vo[i]);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL op%0d_valid got %b want 1", i, rsp_valid); end
      checks++; if (rsp_result !== vr[i]) begin errors++; $display("FAIL op%0d_result got %h want %h", i, rsp_result, vr[i]); end
      checks++; if (rsp_flags !== vf[i]) begin errors++; $display("FAIL op%0d_flags got %b want %b", i, rsp_flags, vf[i]); end
      checks++; if (sticky_v !== (STICKY_EN & vf[i][0])) begin errors++; $display("FAIL op%0d_sticky got %b want %b", i, sticky_v, STICKY_EN & vf[i][0]); end
      rsp_ready = 1'b1; clr_sticky = 1'b1;
      tick();
      rsp_ready = 1'b0; clr_sticky = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL op%0d_popped got %b want 0", i, rsp_valid); end
      checks++; if (sticky_v !== 1'b0) begin errors++; $display("FAIL op%0d_clr got %b want 0", i, sticky_v); end
    end
  endtask

  task automatic test_full();
    rsp_ready = 1'b0;
    issue(32'd10, 32'd1, 2'b00);
    issue(32'd20, 32'd2, 2'b00);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready got %b want 0", req_ready); end
    checks++; if (rsp_result !== 32'd11) begin errors++; $display("FAIL full_head0 got %0d want 11", rsp_result); end
    req_a = 32'd99; req_b = 32'd0; req_ctrl = 2'b00; req_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready got %b want 1", req_ready); end
    checks++; if (rsp_result !== 32'd22) begin errors++; $display("FAIL full_head1 got %0d want 22", rsp_result); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL full_no_passthru got valid %b result %0d want valid 0", rsp_valid, rsp_result); end
  endtask

  task automatic test_back_to_back();
    int nrecv = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) begin
        req_a = 32'(c * 3 + 1); req_b = 32'(c); req_ctrl = 2'b00; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      if (c > 0) begin
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid cycle %0d got %b want 1", c, rsp_valid); end
        checks++; if (rsp_result !== 32'((nrecv) * 4 + 1)) begin errors++; $display("FAIL b2b_result %0d got %0d want %0d", nrecv, rsp_result, nrecv * 4 + 1); end
        if (rsp_valid === 1'b1) nrecv++;
      end
      if (c < 10) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cycle %0d got %b want 1", c, req_ready); end
      end
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (nrecv !== 10) begin errors++; $display("FAIL b2b_count got %0d want 10", nrecv); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", rsp_valid); end
  endtask

  task automatic test_midstream_reset();
    issue(32'h7FFF_FFFF, 32'h1, 2'b00);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_fill got %b want 1", rsp_valid); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (sticky_v !== 1'b0) begin errors++; $display("FAIL mid_sticky got %b want 0", sticky_v); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL mid_result got %h want 0", rsp_result); end
  endtask

  task automatic test_sticky_priority();
    clr_sticky = 1'b1;
    issue(32'h7FFF_FFFF, 32'h1, 2'b00);
    clr_sticky = 1'b0;
    checks++; if (sticky_v !== STICKY_EN) begin errors++; $display("FAIL set_wins got %b want %b", sticky_v, STICKY_EN); end
    checks++; if (rsp_flags !== 4'b1001) begin errors++; $display("FAIL set_wins_flags got %b want 1001", rsp_flags); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (sticky_v !== STICKY_EN) begin errors++; $display("FAIL sticky_hold got %b want %b", sticky_v, STICKY_EN); end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++; if (sticky_v !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b want 0", sticky_v); end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_ctrl = 2'b00;
    rsp_ready = 1'b0; clr_sticky = 1'b0;
    test_reset();
    test_ops();
    test_full();
    test_back_to_back();
    test_midstream_reset();
    test_sticky_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
